// File: rtl/xnor_sweep_checker.sv
// Sweeps {a,b,c} through all 8 vectors and checks an external XNOR SOP block against ~(a^b^c).
// Optional build macro MISMATCH_LOG_EN adds first_fail_vld/first_fail_vec capture of the first mismatch.
module xnor_sweep_checker #(
  parameter int DWELL = 4,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             f_in,
  output logic             a_out,
  output logic             b_out,
  output logic             c_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
`ifdef MISMATCH_LOG_EN
  ,
  output logic             first_fail_vld,
  output logic [2:0]       first_fail_vec
`endif
);

  localparam int              CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_next;
  logic [2:0]       r_vec, w_vec_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [ERR_W-1:0] r_err, w_err_next;
  logic             r_busy, w_busy_next;
  logic             r_done, w_done_next;
  logic             r_pass, w_pass_next;
  logic             w_sample;
  logic             w_mismatch;

`ifdef MISMATCH_LOG_EN
  logic       r_ff_vld, w_ff_vld_next;
  logic [2:0] r_ff_vec, w_ff_vec_next;
`endif

  // f_in has had the whole dwell to settle from the current vector by the last dwell cycle
  assign w_sample   = (r_state == S_RUN) && (r_cnt == CNT_LAST);
  assign w_mismatch = w_sample && (f_in != (~^r_vec));

  always_comb begin
    w_state_next = r_state;
    w_vec_next   = r_vec;
    w_cnt_next   = r_cnt;
    w_err_next   = r_err;
    w_busy_next  = r_busy;
    w_done_next  = r_done;
    w_pass_next  = r_pass;
`ifdef MISMATCH_LOG_EN
    w_ff_vld_next = r_ff_vld;
    w_ff_vec_next = r_ff_vec;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_next = S_RUN;
          w_vec_next   = 3'b111;
          w_cnt_next   = '0;
          w_err_next   = '0;
          w_busy_next  = 1'b1;
          w_done_next  = 1'b0;
          w_pass_next  = 1'b0;
`ifdef MISMATCH_LOG_EN
          w_ff_vld_next = 1'b0;
          w_ff_vec_next = 3'b000;
`endif
        end
      end
      S_RUN: begin
        w_cnt_next = r_cnt + CNT_W'(1);
        if (w_sample) begin
          w_cnt_next = '0;
          w_vec_next = r_vec - 3'd1;
          if (w_mismatch && (r_err != ERR_MAX)) begin
            w_err_next = r_err + ERR_W'(1);
          end
`ifdef MISMATCH_LOG_EN
          if (w_mismatch && !r_ff_vld) begin
            w_ff_vld_next = 1'b1;
            w_ff_vec_next = r_vec;
          end
`endif
          // vector 000 is the eighth and last sample
          if (r_vec == 3'b000) begin
            w_state_next = S_DONE;
            w_vec_next   = 3'b000;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
            w_pass_next  = (w_err_next == '0);
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_vec   <= 3'b000;
      r_cnt   <= '0;
      r_err   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
`ifdef MISMATCH_LOG_EN
      r_ff_vld <= 1'b0;
      r_ff_vec <= 3'b000;
`endif
    end else begin
      r_state <= w_state_next;
      r_vec   <= w_vec_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      r_pass  <= w_pass_next;
`ifdef MISMATCH_LOG_EN
      r_ff_vld <= w_ff_vld_next;
      r_ff_vec <= w_ff_vec_next;
`endif
    end
  end

  assign a_out     = r_vec[2];
  assign b_out     = r_vec[1];
  assign c_out     = r_vec[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
`ifdef MISMATCH_LOG_EN
  assign first_fail_vld = r_ff_vld;
  assign first_fail_vec = r_ff_vec;
`endif

endmodule

// File: tb/tb_xnor_sweep_checker.sv
// Directed bench for xnor_sweep_checker: three instances (DWELL=4/ERR_W=4, DWELL=4/ERR_W=2, DWELL=1/ERR_W=4)
// driven by a behavioural SOP block that can be correct, stuck at 0 or inverted.
module tb_xnor_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start_v;
  int         mode;
  int         sel;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         dw_tab[3] = '{4, 4, 1};

  logic [2:0] a_v, b_v, c_v, f_v, busy_v, done_v, pass_v;
  logic [3:0] err0, err2;
  logic [1:0] err1;
  logic       ffv_v [3];
  logic [2:0] ffvec_v [3];

  logic       m_busy, m_done, m_pass;
  logic [2:0] m_vec;
  logic [3:0] m_err;

  always #5 clk = ~clk;

  // Block under test: 0 = correct XNOR, 1 = stuck at 0, 2 = inverted XNOR
  function automatic logic f_model(input int m, input logic a, input logic b, input logic c);
    logic x;
    x = ~(a ^ b ^ c);
    case (m)
      1:       return 1'b0;
      2:       return ~x;
      default: return x;
    endcase
  endfunction

  assign f_v[0] = f_model(mode, a_v[0], b_v[0], c_v[0]);
  assign f_v[1] = f_model(mode, a_v[1], b_v[1], c_v[1]);
  assign f_v[2] = f_model(mode, a_v[2], b_v[2], c_v[2]);

  xnor_sweep_checker #(.DWELL(4), .ERR_W(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .f_in(f_v[0]),
    .a_out(a_v[0]), .b_out(b_v[0]), .c_out(c_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err0)
`ifdef MISMATCH_LOG_EN
    , .first_fail_vld(ffv_v[0]), .first_fail_vec(ffvec_v[0])
`endif
  );

  xnor_sweep_checker #(.DWELL(4), .ERR_W(2)) u_e2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .f_in(f_v[1]),
    .a_out(a_v[1]), .b_out(b_v[1]), .c_out(c_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err1)
`ifdef MISMATCH_LOG_EN
    , .first_fail_vld(ffv_v[1]), .first_fail_vec(ffvec_v[1])
`endif
  );

  xnor_sweep_checker #(.DWELL(1), .ERR_W(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .f_in(f_v[2]),
    .a_out(a_v[2]), .b_out(b_v[2]), .c_out(c_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err2)
`ifdef MISMATCH_LOG_EN
    , .first_fail_vld(ffv_v[2]), .first_fail_vec(ffvec_v[2])
`endif
  );

  always_comb begin
    m_busy = busy_v[sel];
    m_done = done_v[sel];
    m_pass = pass_v[sel];
    m_vec  = {a_v[sel], b_v[sel], c_v[sel]};
    if (sel == 1)      m_err = {2'b00, err1};
    else if (sel == 2) m_err = err2;
    else               m_err = err0;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, got);
    end
  endtask

  // Starts a sweep on instance sel from a negedge; returns edge index at which done was first seen.
  task automatic sweep(input bit hold, output int cyc, output int bcnt, output int verr);
    start_v[sel] = 1'b1;
    @(negedge clk);
    if (!hold) start_v[sel] = 1'b0;
    cyc  = 0;
    bcnt = 0;
    verr = 0;
    while (!m_done && cyc < 400) begin
      if (m_busy) bcnt++;
      if (int'(m_vec) != 7 - cyc / dw_tab[sel]) verr++;
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int cyc, bcnt, verr, k;
    rst_n   = 1'b0;
    start_v = 3'b000;
    mode    = 0;
    sel     = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(m_busy), 0);
    check("rst_done", int'(m_done), 0);
    check("rst_pass", int'(m_pass), 0);
    check("rst_err",  int'(m_err), 0);
    check("rst_vec",  int'(m_vec), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: correct model, DWELL=4
    sweep(1'b0, cyc, bcnt, verr);
    check("t1_done_edge", cyc, 32);
    check("t1_busy_cycles", bcnt, 32);
    check("t1_vec_seq_errs", verr, 0);
    check("t1_busy_end", int'(m_busy), 0);
    check("t1_pass", int'(m_pass), 1);
    check("t1_err", int'(m_err), 0);
    check("t1_vec_end", int'(m_vec), 0);
`ifdef MISMATCH_LOG_EN
    check("t1_ff_vld", int'(ffv_v[0]), 0);
    check("t1_ff_vec", int'(ffvec_v[0]), 0);
`endif
    @(negedge clk);
    check("t1_done_held", int'(m_done), 1);

    // 2: stuck-at-0 output
    mode = 1;
    sweep(1'b0, cyc, bcnt, verr);
    check("t2_done_edge", cyc, 32);
    check("t2_err", int'(m_err), 4);
    check("t2_pass", int'(m_pass), 0);
`ifdef MISMATCH_LOG_EN
    check("t2_ff_vld", int'(ffv_v[0]), 1);
    check("t2_ff_vec", int'(ffvec_v[0]), 6);
`endif

    // 3: ERR_W=2 with inverted output saturates at 3
    sel  = 1;
    mode = 2;
    sweep(1'b0, cyc, bcnt, verr);
    check("t3_done_edge", cyc, 32);
    check("t3_err_sat", int'(m_err), 3);
    check("t3_pass", int'(m_pass), 0);

    // 4: asynchronous reset mid-sweep
    sel  = 0;
    mode = 1;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (12) @(negedge clk);
    check("t4_err_before_rst", int'(m_err), 2);
    check("t4_busy_before_rst", int'(m_busy), 1);
    rst_n = 1'b0;
    #1;
    check("t4_rst_busy", int'(m_busy), 0);
    check("t4_rst_done", int'(m_done), 0);
    check("t4_rst_err", int'(m_err), 0);
    check("t4_rst_vec", int'(m_vec), 0);
    check("t4_rst_pass", int'(m_pass), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mode  = 0;
    @(negedge clk);
    sweep(1'b0, cyc, bcnt, verr);
    check("t4_resweep_edge", cyc, 32);
    check("t4_resweep_vec_errs", verr, 0);
    check("t4_resweep_pass", int'(m_pass), 1);

    // 5: start held high throughout
    mode = 1;
    sweep(1'b1, cyc, bcnt, verr);
    check("t5_done_edge", cyc, 32);
    check("t5_busy_cycles", bcnt, 32);
    check("t5_vec_seq_errs", verr, 0);
    check("t5_err", int'(m_err), 4);
    @(negedge clk);
    check("t5_done_1cycle", int'(m_done), 0);
    check("t5_restart_busy", int'(m_busy), 1);
    check("t5_restart_err", int'(m_err), 0);
    check("t5_restart_vec", int'(m_vec), 7);
    start_v[0] = 1'b0;
    k = 0;
    while (!m_done && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t5_second_done", int'(m_done), 1);

    // 6: DWELL=1
    sel  = 2;
    mode = 0;
    sweep(1'b0, cyc, bcnt, verr);
    check("t6_done_edge", cyc, 8);
    check("t6_busy_cycles", bcnt, 8);
    check("t6_vec_seq_errs", verr, 0);
    check("t6_pass", int'(m_pass), 1);
    check("t6_err", int'(m_err), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
